// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: op-code encodings, FSM states and the NZCV flag bundle.
// Op 1010 (ALU_MUL) is only a legal operation when the design is built with ALU_MUL_EN defined.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001,
      ALU_MUL  = 4'b1010
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   typedef struct packed {
      logic Zero;
      logic Negative;
      logic Carry;
      logic Overflow;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b, one multiplier bit per cycle.
// Only instantiated by alu_mc when ALU_MUL_EN is defined.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product_lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    count;
   logic             active;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;

   // The first multiplier bit is consumed on the start edge itself, so the
   // remaining WIDTH-1 bits finish exactly WIDTH cycles after acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         active <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         acc    <= b[0] ? a : '0;
         mcand  <= a << 1;
         mplier <= b >> 1;
         count  <= CW'(WIDTH - 1);
         active <= 1'b1;
      end else if (active) begin
         if (count != '0) begin
            if (mplier[0]) begin
               acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
         end else begin
            active <= 1'b0;
         end
      end
   end

   assign done       = active && (count == '0);
   assign product_lo = acc;

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: SrcB mux, single-cycle op unit, NZCV flags, IDLE/BUSY/DONE FSM.
// Define ALU_MUL_EN to include the iterative multiplier; otherwise op 1010 is treated as illegal.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] RegData2,
   input  logic [WIDTH-1:0] ImmExt,
   input  logic             ALUSrc,
   input  logic [3:0]       ALUControl,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow,
   output logic             OutValid,
   input  logic             OutReady
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_t       state;
   alu_flags_t       flags_q;
   alu_flags_t       op_flags;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] op_result;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;
   logic             is_sub;
   logic             is_arith;
   logic             accept;
   logic             mul_op;

   assign src_b    = ALUSrc ? ImmExt : RegData2;
   assign shamt    = src_b[SHW-1:0];
   assign is_sub   = (ALUControl == ALU_SUB);
   assign is_arith = (ALUControl == ALU_ADD) || is_sub;

   // SUB shares the adder as A + ~B + 1, so carry-out reads as "no borrow".
   assign b_eff = is_sub ? ~src_b : src_b;
   assign sum   = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      op_result = '0;
      case (ALUControl)
         ALU_ADD,
         ALU_SUB:  op_result = sum[WIDTH-1:0];
         ALU_AND:  op_result = SrcA & src_b;
         ALU_OR:   op_result = SrcA | src_b;
         ALU_XOR:  op_result = SrcA ^ src_b;
         ALU_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(src_b))};
         ALU_SLTU: op_result = {{(WIDTH-1){1'b0}}, (SrcA < src_b)};
         ALU_SLL:  op_result = SrcA << shamt;
         ALU_SRL:  op_result = SrcA >> shamt;
         ALU_SRA:  op_result = $unsigned($signed(SrcA) >>> shamt);
         default:  op_result = '0;
      endcase
   end

   always_comb begin
      op_flags          = '0;
      op_flags.Zero     = (op_result == '0);
      op_flags.Negative = op_result[WIDTH-1];
      op_flags.Carry    = is_arith && sum[WIDTH];
      op_flags.Overflow = is_arith && (SrcA[WIDTH-1] == b_eff[WIDTH-1])
                                   && (op_result[WIDTH-1] != SrcA[WIDTH-1]);
   end

   assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
   assign accept   = InValid && InReady;
   assign OutValid = (state == DONE);

`ifdef ALU_MUL_EN
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   alu_flags_t       mul_flags;

   assign mul_op = (ALUControl == ALU_MUL);

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && mul_op),
      .a         (SrcA),
      .b         (src_b),
      .done      (mul_done),
      .product_lo(mul_product)
   );

   always_comb begin
      mul_flags          = '0;
      mul_flags.Zero     = (mul_product == '0);
      mul_flags.Negative = mul_product[WIDTH-1];
   end
`else
   assign mul_op = 1'b0;
`endif

   // Result and flags only load on a completed op, so they hold steady while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         case (state)
`ifdef ALU_MUL_EN
            BUSY: begin
               if (mul_done) begin
                  state    <= DONE;
                  result_q <= mul_product;
                  flags_q  <= mul_flags;
               end
            end
`endif
            default: begin
               if (accept) begin
                  if (mul_op) begin
                     state <= BUSY;
                  end else begin
                     state    <= DONE;
                     result_q <= op_result;
                     flags_q  <= op_flags;
                  end
               end else if (OutReady) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign ALUResult = result_q;
   assign Zero      = flags_q.Zero;
   assign Negative  = flags_q.Negative;
   assign Carry     = flags_q.Carry;
   assign Overflow  = flags_q.Overflow;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH = 32); multiplier scenarios follow ALU_MUL_EN.
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] SrcA;
   logic [31:0] RegData2;
   logic [31:0] ImmExt;
   logic        ALUSrc;
   logic [3:0]  ALUControl;
   logic        InValid;
   logic        InReady;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        Negative;
   logic        Carry;
   logic        Overflow;
   logic        OutValid;
   logic        OutReady;
   wire  [3:0]  zncv = {Zero, Negative, Carry, Overflow};

   int checks;
   int errors;

   alu_mc #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .SrcA      (SrcA),
      .RegData2  (RegData2),
      .ImmExt    (ImmExt),
      .ALUSrc    (ALUSrc),
      .ALUControl(ALUControl),
      .InValid   (InValid),
      .InReady   (InReady),
      .ALUResult (ALUResult),
      .Zero      (Zero),
      .Negative  (Negative),
      .Carry     (Carry),
      .Overflow  (Overflow),
      .OutValid  (OutValid),
      .OutReady  (OutReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rb,
                        input logic [31:0] imm, input logic src);
      ALUControl = op;
      SrcA       = a;
      RegData2   = rb;
      ImmExt     = imm;
      ALUSrc     = src;
      InValid    = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      InValid = 1'b0; OutReady = 1'b1; ALUSrc = 1'b0; ALUControl = 4'h0;
      SrcA = '0; RegData2 = '0; ImmExt = '0;
      @(negedge clk); @(negedge clk);
      checks++; if (ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", ALUResult); end
      checks++; if (zncv !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b want 0000", zncv); end
      checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outvalid got %b want 0", OutValid); end
      checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_inready got %b want 1", InReady); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add_overflow();
      drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_0000, 1'b0);
      @(negedge clk);
      InValid = 1'b0;
      checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL add_outvalid got %b want 1", OutValid); end
      checks++; if (ALUResult !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_result got %h want 80000000", ALUResult); end
      checks++; if (zncv !== 4'b0101) begin errors++; $display("[TB] FAIL add_flags got %b want 0101", zncv); end
      @(negedge clk);
      checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL add_drain got %b want 0", OutValid); end
   endtask

   task automatic test_sub_slt();
      drive(ALU_SUB, 32'h5, 32'h63, 32'h5, 1'b1);
      @(negedge clk);
      checks++; if (ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL sub_result got %h want 0", ALUResult); end
      checks++; if (zncv !== 4'b1010) begin errors++; $display("[TB] FAIL sub_flags got %b want 1010", zncv); end
      drive(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
      @(negedge clk);
      checks++; if (ALUResult !== 32'h1) begin errors++; $display("[TB] FAIL slt_result got %h want 1", ALUResult); end
      checks++; if (zncv !== 4'b0000) begin errors++; $display("[TB] FAIL slt_flags got %b want 0000", zncv); end
      drive(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
      @(negedge clk);
      InValid = 1'b0;
      checks++; if (ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL sltu_result got %h want 0", ALUResult); end
      checks++; if (zncv !== 4'b1000) begin errors++; $display("[TB] FAIL sltu_flags got %b want 1000", zncv); end
      @(negedge clk);
   endtask

   task automatic test_shifts();
      drive(ALU_SRA, 32'h8000_0000, 32'h24, 32'h0, 1'b0);
      @(negedge clk);
      checks++; if (ALUResult !== 32'hF800_0000) begin errors++; $display("[TB] FAIL sra_result got %h want f8000000", ALUResult); end
      checks++; if (zncv !== 4'b0100) begin errors++; $display("[TB] FAIL sra_flags got %b want 0100", zncv); end
      drive(ALU_SRL, 32'h8000_0000, 32'h0, 32'h24, 1'b1);
      @(negedge clk);
      InValid = 1'b0;
      checks++; if (ALUResult !== 32'h0800_0000) begin errors++; $display("[TB] FAIL srl_result got %h want 08000000", ALUResult); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [3:0]  op  [7];
      logic [31:0] a   [7];
      logic [31:0] b   [7];
      logic [31:0] res [7];
      logic [3:0]  fl  [7];
      op  = '{4'h2, 4'h3, 4'h1, 4'h1, 4'h0, 4'h4, 4'h7};
      a   = '{32'hFF00_FF00, 32'hFF00_FF00, 32'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h1};
      b   = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h5, 32'h1, 32'h1, 32'hAAAA_AAAA, 32'h3F};
      res = '{32'h0F00_0F00, 32'hFF0F_FF0F, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h8000_0000};
      fl  = '{4'b0000, 4'b0100, 4'b0100, 4'b0011, 4'b1010, 4'b1000, 4'b0100};
      for (int i = 0; i < 7; i++) begin
         drive(op[i], a[i], b[i], 32'h1234_5678, 1'b0);
         checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d] got %b want 1", i, InReady); end
         @(negedge clk);
         checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got %b want 1", i, OutValid); end
         checks++; if (ALUResult !== res[i]) begin errors++; $display("[TB] FAIL b2b_result[%0d] got %h want %h", i, ALUResult, res[i]); end
         checks++; if (zncv !== fl[i]) begin errors++; $display("[TB] FAIL b2b_flags[%0d] got %b want %b", i, zncv, fl[i]); end
      end
      InValid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mul();
`ifdef ALU_MUL_EN
      logic [31:0] mul_a [2];
      logic [31:0] mul_b [2];
      logic [31:0] mul_p [2];
      logic [3:0]  mul_f [2];
      int cycles;
      bit ready_seen;
      mul_a = '{32'h0000_FFFF, 32'h0001_2345};
      mul_b = '{32'h0001_0001, 32'h0000_0100};
      mul_p = '{32'hFFFF_FFFF, 32'h0123_4500};
      mul_f = '{4'b0100, 4'b0000};
      for (int i = 0; i < 2; i++) begin
         drive(ALU_MUL, mul_a[i], mul_b[i], 32'h0, 1'b0);
         @(negedge clk);
         InValid = 1'b0;
         SrcA = 32'hDEAD_BEEF; RegData2 = 32'h0BAD_F00D;
         cycles = 1;
         ready_seen = 1'b0;
         while (!OutValid && cycles < 100) begin
            if (InReady) ready_seen = 1'b1;
            @(negedge clk);
            cycles++;
         end
         checks++; if (cycles != 33) begin errors++; $display("[TB] FAIL mul_latency[%0d] got %0d want 33", i, cycles); end
         checks++; if (ready_seen) begin errors++; $display("[TB] FAIL mul_busy_ready[%0d] got 1 want 0", i); end
         checks++; if (ALUResult !== mul_p[i]) begin errors++; $display("[TB] FAIL mul_result[%0d] got %h want %h", i, ALUResult, mul_p[i]); end
         checks++; if (zncv !== mul_f[i]) begin errors++; $display("[TB] FAIL mul_flags[%0d] got %b want %b", i, zncv, mul_f[i]); end
      end
      @(negedge clk);
`else
      drive(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 1'b0);
      @(negedge clk);
      InValid = 1'b0;
      checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL mul_off_valid got %b want 1", OutValid); end
      checks++; if (ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL mul_off_result got %h want 0", ALUResult); end
      checks++; if (zncv !== 4'b1000) begin errors++; $display("[TB] FAIL mul_off_flags got %b want 1000", zncv); end
      @(negedge clk);
`endif
   endtask

   task automatic test_stall();
      OutReady = 1'b0;
      drive(ALU_ADD, 32'h1, 32'h2, 32'h0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         drive(ALU_SUB, 32'h100 + i, 32'h7, 32'h0, 1'b0);
         #1;
         checks++; if (ALUResult !== 32'h3) begin errors++; $display("[TB] FAIL stall_result[%0d] got %h want 3", i, ALUResult); end
         checks++; if (zncv !== 4'b0000) begin errors++; $display("[TB] FAIL stall_flags[%0d] got %b want 0000", i, zncv); end
         checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, OutValid); end
         checks++; if (InReady !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready[%0d] got %b want 0", i, InReady); end
         @(negedge clk);
      end
      drive(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b0);
      OutReady = 1'b1;
      #1;
      checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b want 1", InReady); end
      @(negedge clk);
      InValid = 1'b0;
      checks++; if (ALUResult !== 32'h0000_0FF0) begin errors++; $display("[TB] FAIL release_result got %h want 00000ff0", ALUResult); end
      checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL release_valid got %b want 1", OutValid); end
      @(negedge clk);
      checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL release_drain got %b want 0", OutValid); end
   endtask

   task automatic test_reset_mid_op();
      bit valid_seen;
`ifdef ALU_MUL_EN
      drive(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 1'b0);
      @(negedge clk);
      InValid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (ALUResult !== 32'h0 || zncv !== 4'b0000) begin errors++; $display("[TB] FAIL mulrst_outputs got %h/%b want 0/0000", ALUResult, zncv); end
      checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL mulrst_ready got %b want 1", InReady); end
      @(negedge clk);
      reset = 1'b0;
      valid_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (OutValid) valid_seen = 1'b1;
      end
      checks++; if (valid_seen) begin errors++; $display("[TB] FAIL mulrst_spurious got 1 want 0"); end
`endif
      OutReady = 1'b0;
      drive(ALU_ADD, 32'h1, 32'h2, 32'h0, 1'b0);
      @(negedge clk);
      InValid = 1'b0;
      checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL held_valid got %b want 1", OutValid); end
      reset = 1'b1;
      #1;
      checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL drop_valid got %b want 0", OutValid); end
      checks++; if (ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL drop_result got %h want 0", ALUResult); end
      checks++; if (InReady !== 1'b1) begin errors++; $display("[TB] FAIL drop_ready got %b want 1", InReady); end
      @(negedge clk);
      reset = 1'b0;
      OutReady = 1'b1;
      valid_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (OutValid) valid_seen = 1'b1;
      end
      checks++; if (valid_seen) begin errors++; $display("[TB] FAIL drop_spurious got 1 want 0"); end
   endtask

   task automatic test_illegal();
      drive(4'b1111, 32'h5, 32'h3, 32'h0, 1'b0);
      @(negedge clk);
      drive(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
      checks++; if (ALUResult !== 32'h0) begin errors++; $display("[TB] FAIL illegal_result got %h want 0", ALUResult); end
      checks++; if (zncv !== 4'b1000) begin errors++; $display("[TB] FAIL illegal_flags got %b want 1000", zncv); end
      checks++; if (OutValid !== 1'b1) begin errors++; $display("[TB] FAIL illegal_valid got %b want 1", OutValid); end
      @(negedge clk);
      InValid = 1'b0;
      checks++; if (ALUResult !== 32'h0 || zncv !== 4'b1000) begin errors++; $display("[TB] FAIL illegal2 got %h/%b want 0/1000", ALUResult, zncv); end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add_overflow();
      test_sub_slt();
      test_shifts();
      test_back_to_back();
      test_mul();
      test_stall();
      test_reset_mid_op();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
